// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the divider counters and their index decoder:
// FSM encoding, default feedback masks and the single-step next-state function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } dec_state_t;

  localparam logic [25:0] TAPS_W26 = 26'h2000023;
  localparam logic [3:0]  TAPS_W4  = 4'hC;

  // Widths without a tabulated mask get {msb, bit0}, which keeps the map invertible.
  function automatic logic [63:0] default_taps(input int width);
    case (width)
      26:      return 64'(TAPS_W26);
      4:       return 64'(TAPS_W4);
      default: return (64'd1 << (width - 1)) | 64'd1;
    endcase
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int          width);
    logic [63:0] mask;
    logic        fb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    fb   = ^(state & taps);
    return {state[62:0], fb} & mask;
  endfunction

endpackage

// File: rtl/lfsr_index_decoder_next_state.sv
// Combinational single LFSR step: feedback is the parity of the tapped bits,
// shifted in at bit 0.
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = WIDTH'(lfsr_next(64'(state), 64'(TAPS), WIDTH));

endmodule

// File: rtl/lfsr_index_decoder.sv
// Discrete-log decoder: finds the step index of an LFSR state by running a shadow
// LFSR from SEED. Define LFSR_DEC_STEP2_EN to test two sequence positions per cycle.
module lfsr_index_decoder
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_index,
  output logic             out_found
);

  // Last index of a full 2^WIDTH-1 period; reaching it unmatched means not found.
  localparam logic [WIDTH-1:0] LAST_IDX = {{(WIDTH-1){1'b1}}, 1'b0};

  dec_state_t       state, state_nxt;
  logic [WIDTH-1:0] target, shadow, count, idx_q;
  logic             found_q;
  logic [WIDTH-1:0] shadow_nxt1, shadow_adv;
  logic             target_zero, hit0, at_last, search_end;

  lfsr_next_state #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step1 (
    .state (shadow),
    .nxt   (shadow_nxt1)
  );

  assign target_zero = (target == '0);
  assign hit0        = (shadow == target);
  assign at_last     = (count == LAST_IDX);

`ifdef LFSR_DEC_STEP2_EN
  localparam logic [WIDTH-1:0] STEP_INC = WIDTH'(2);
  logic [WIDTH-1:0] shadow_nxt2;
  logic             hit1;

  lfsr_next_state #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step2 (
    .state (shadow_nxt1),
    .nxt   (shadow_nxt2)
  );

  // At the final even index, k+1 would be past the period and is not a valid answer.
  assign hit1       = (shadow_nxt1 == target) && !at_last;
  assign shadow_adv = shadow_nxt2;
  assign search_end = target_zero | hit0 | hit1 | at_last;
`else
  localparam logic [WIDTH-1:0] STEP_INC = WIDTH'(1);
  assign shadow_adv = shadow_nxt1;
  assign search_end = target_zero | hit0 | at_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid)   state_nxt = ST_SEARCH;
      ST_SEARCH: if (search_end) state_nxt = ST_DONE;
      ST_DONE:   if (out_ready)  state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    out_index = idx_q;
    out_found = found_q;
  end

  // A zero target is resolved in the first search cycle, before any shadow compare,
  // so it can never be reported as found even with degenerate taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      shadow  <= '0;
      count   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            target  <= in_state;
            shadow  <= SEED;
            count   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
          end
        end
        ST_SEARCH: begin
          if (target_zero) begin
            idx_q   <= '0;
            found_q <= 1'b0;
          end else if (hit0) begin
            idx_q   <= count;
            found_q <= 1'b1;
`ifdef LFSR_DEC_STEP2_EN
          end else if (hit1) begin
            idx_q   <= count + WIDTH'(1);
            found_q <= 1'b1;
`endif
          end else if (at_last) begin
            idx_q   <= '0;
            found_q <= 1'b0;
          end else begin
            shadow <= shadow_adv;
            count  <= count + STEP_INC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_index_decoder.sv
// Scoreboard bench for lfsr_index_decoder: a maximal 4-bit, a short-period 4-bit
// and the default 26-bit instance, checked against an independent LFSR model.
module tb_lfsr_index_decoder;

  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_state;
  logic         out_ready;

  logic         iv_c, ir_c, ov_c, fd_c;
  logic [3:0]   oi_c;
  logic         iv_n, ir_n, ov_n, fd_n;
  logic [3:0]   oi_n;
  logic         iv_w, ir_w, ov_w, fd_w;
  logic [W-1:0] oi_w;

  always #5 clk = ~clk;

  lfsr_index_decoder #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in_state(in_state[3:0]),
    .out_valid(ov_c), .out_ready(out_ready), .out_index(oi_c), .out_found(fd_c)
  );

  lfsr_index_decoder #(.WIDTH(4), .TAPS(4'hF), .SEED(4'h1)) dut_n (
    .clk(clk), .rst(rst), .in_valid(iv_n), .in_ready(ir_n), .in_state(in_state[3:0]),
    .out_valid(ov_n), .out_ready(out_ready), .out_index(oi_n), .out_found(fd_n)
  );

  lfsr_index_decoder dut_w (
    .clk(clk), .rst(rst), .in_valid(iv_w), .in_ready(ir_w), .in_state(in_state),
    .out_valid(ov_w), .out_ready(out_ready), .out_index(oi_w), .out_found(fd_w)
  );

  typedef struct {
    int          dut;
    logic [63:0] idx;
    logic [63:0] found;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dut_w_of(input int d);
    return (d == 2) ? W : 4;
  endfunction

  function automatic logic [W-1:0] dut_taps(input int d);
    case (d)
      0:       return W'(4'hC);
      1:       return W'(4'hF);
      default: return 26'h2000023;
    endcase
  endfunction

  function automatic logic [63:0] get_ov(input int d);
    case (d)
      0:       return 64'(ov_c);
      1:       return 64'(ov_n);
      default: return 64'(ov_w);
    endcase
  endfunction

  function automatic logic [63:0] get_ir(input int d);
    case (d)
      0:       return 64'(ir_c);
      1:       return 64'(ir_n);
      default: return 64'(ir_w);
    endcase
  endfunction

  function automatic logic [63:0] get_idx(input int d);
    case (d)
      0:       return 64'(oi_c);
      1:       return 64'(oi_n);
      default: return 64'(oi_w);
    endcase
  endfunction

  function automatic logic [63:0] get_fnd(input int d);
    case (d)
      0:       return 64'(fd_c);
      1:       return 64'(fd_n);
      default: return 64'(fd_w);
    endcase
  endfunction

  task automatic set_iv(input int d, input logic v);
    iv_c = v && (d == 0);
    iv_n = v && (d == 1);
    iv_w = v && (d == 2);
  endtask

  // Model step: parity of tapped bits shifted in at bit 0, truncated to the width.
  function automatic logic [W-1:0] m_next(input logic [W-1:0] s, input int d);
    logic [W-1:0] taps, res;
    logic         fb;
    int           w;
    w    = dut_w_of(d);
    taps = dut_taps(d);
    fb   = 1'b0;
    for (int i = 0; i < w; i++) fb = fb ^ (s[i] & taps[i]);
    res = {s[W-2:0], fb};
    for (int i = w; i < W; i++) res[i] = 1'b0;
    return res;
  endfunction

  task automatic model_find(input int d, input logic [W-1:0] tgt,
                            output logic found, output logic [63:0] idx);
    logic [W-1:0] s;
    int           w;
    w     = dut_w_of(d);
    s     = W'(1);
    found = 1'b0;
    idx   = 64'd0;
    if (tgt != '0) begin
      for (int k = 0; k <= (1 << w) - 2; k++) begin
        if (!found && s == tgt) begin
          found = 1'b1;
          idx   = 64'(k);
        end
        s = m_next(s, d);
      end
    end
  endtask

  function automatic int exp_lat(input int d, input logic [W-1:0] tgt,
                                 input logic found, input logic [63:0] idx);
    int w;
    w = dut_w_of(d);
    if (tgt == '0) return 1;
`ifdef LFSR_DEC_STEP2_EN
    if (found) return int'(idx / 2) + 1;
    return 1 << (w - 1);
`else
    if (found) return int'(idx) + 1;
    return (1 << w) - 1;
`endif
  endfunction

  task automatic issue(input int d, input logic [W-1:0] tgt,
                       input logic found, input logic [63:0] idx);
    exp_t e;
    e.dut   = d;
    e.idx   = idx;
    e.found = 64'(found);
    e.lat   = exp_lat(d, tgt, found, idx);
    in_state = tgt;
    set_iv(d, 1'b1);
    check("in_ready_at_accept", get_ir(d), 64'd1);
    @(posedge clk);
    #1;
    set_iv(d, 1'b0);
    in_state = ~tgt;
    sb.push_back(e);
  endtask

  task automatic collect(input int bp_cycles);
    exp_t        e;
    int          cyc;
    logic [63:0] held;
    e   = sb.pop_front();
    cyc = 0;
    while (get_ov(e.dut) == 64'd0 && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(e.lat));
    check("out_index", get_idx(e.dut), e.idx);
    check("out_found", get_fnd(e.dut), e.found);
    check("in_ready_busy", get_ir(e.dut), 64'd0);
    held = get_idx(e.dut);
    for (int i = 0; i < bp_cycles; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", get_ov(e.dut), 64'd1);
      check("bp_out_index", get_idx(e.dut), held);
      check("bp_in_ready", get_ir(e.dut), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_in_ready", get_ir(e.dut), 64'd1);
    check("post_hs_out_valid", get_ov(e.dut), 64'd0);
  endtask

  task automatic run(input int d, input logic [W-1:0] tgt,
                     input logic found, input logic [63:0] idx);
    issue(d, tgt, found, idx);
    collect(0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         f;
    logic [63:0]  ix;
    logic [W-1:0] s;
    int           k, seen;

    rst       = 1'b1;
    in_state  = '0;
    out_ready = 1'b1;
    set_iv(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", get_ir(d), 64'd1);
      check("rst_out_valid", get_ov(d), 64'd0);
      check("rst_out_index", get_idx(d), 64'd0);
      check("rst_out_found", get_fnd(d), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known points on the 4'hC sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8.
    run(0, W'(4'h1), 1'b1, 64'd0);
    run(0, W'(4'hA), 1'b1, 64'd7);
    run(0, W'(4'h8), 1'b1, 64'd14);
    run(0, W'(4'h0), 1'b0, 64'd0);
    run(0, W'(4'h3), 1'b1, 64'd4);

    for (int t = 0; t < 16; t++) begin
      model_find(0, W'(t), f, ix);
      run(0, W'(t), f, ix);
    end

    // 4'hF cycles through 1,3,6,C,8 only.
    run(1, W'(4'h5), 1'b0, 64'd0);
    run(1, W'(4'hC), 1'b1, 64'd3);
    for (int t = 0; t < 16; t++) begin
      model_find(1, W'(t), f, ix);
      run(1, W'(t), f, ix);
    end

    out_ready = 1'b0;
    issue(0, W'(4'hA), 1'b1, 64'd7);
    collect(5);

    in_state = W'(4'h8);
    set_iv(0, 1'b1);
    @(posedge clk);
    #1;
    set_iv(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", get_ir(0), 64'd1);
    check("mid_rst_out_valid", get_ov(0), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ov_c) seen++;
    end
    check("no_result_after_rst", 64'(seen), 64'd0);
    run(0, W'(4'h2), 1'b1, 64'd1);

    for (int i = 0; i < 64; i++) begin
      k = $urandom_range(0, 1023);
      s = W'(1);
      for (int j = 0; j < k; j++) s = m_next(s, 2);
      run(2, s, 1'b1, 64'(k));
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
